// File: rtl/trap_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_unit_pkg
//   Shared definitions for the machine-mode trap controller:
//   - FSM state encoding (WFI_WAIT is only reachable when TRAP_CTRL_WFI_EN
//     is defined; its encoding stays reserved otherwise)
//   - PC mux select codes driven on pc_src_out
//   - Exception and interrupt cause codes driven on cause_out
//   - Packed groupings of the exception flags and the mie/mip bits
//   - Helper that tells whether any interrupt is pending and enabled in mie,
//     ignoring mstatus.MIE (used for the WFI wake-up condition)
// ---------------------------------------------------------------------------
package trap_ctrl_unit_pkg;

   typedef enum logic [2:0] {
      ST_RESET       = 3'd0,
      ST_OPERATING   = 3'd1,
      ST_TRAP_TAKEN  = 3'd2,
      ST_TRAP_RETURN = 3'd3,
      ST_WFI_WAIT    = 3'd4
   } trap_state_e;

   // PC mux select
   localparam logic [1:0] PC_SRC_BOOT = 2'b00;
   localparam logic [1:0] PC_SRC_EPC  = 2'b01;
   localparam logic [1:0] PC_SRC_TRAP = 2'b10;
   localparam logic [1:0] PC_SRC_NEXT = 2'b11;

   // Exception cause codes (i_or_e = 0)
   localparam logic [3:0] CAUSE_MISALIGNED_INSTR = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_MISALIGNED_LOAD  = 4'd4;
   localparam logic [3:0] CAUSE_MISALIGNED_STORE = 4'd6;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

   // Interrupt cause codes (i_or_e = 1)
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;
   localparam logic [3:0] CAUSE_MEI = 4'd11;

   // Decoder exception flags for the current instruction
   typedef struct packed {
      logic misaligned_instr;
      logic illegal_instr;
      logic ebreak;
      logic misaligned_load;
      logic misaligned_store;
      logic ecall;
   } exc_flags_t;

   // mie enable bits and mip pending bits
   typedef struct packed {
      logic meie;
      logic mtie;
      logic msie;
      logic meip;
      logic mtip;
      logic msip;
   } irq_bits_t;

   // Any source both enabled in mie and pending in mip (mstatus.MIE not applied)
   function automatic logic irq_pending(input irq_bits_t b);
      return (b.meie & b.meip) | (b.msie & b.msip) | (b.mtie & b.mtip);
   endfunction

endpackage

// File: rtl/trap_ctrl_unit_priority_enc.sv
// ---------------------------------------------------------------------------
// trap_priority_enc
//   Purely combinational trap arbiter. Interrupts (only when mstatus.MIE is
//   set) take precedence over synchronous exceptions.
//     interrupts : MEI(11) > MSI(3) > MTI(7)
//     exceptions : misaligned_instr(0) > illegal(2) > ebreak(3)
//                  > misaligned_load(4) > misaligned_store(6) > ecall(11)
//   Ports:
//     exc_in      in   exception flags of the current instruction
//     mie_in      in   mstatus.MIE
//     irq_in      in   mie/mip bits
//     take_out    out  a trap must be taken
//     i_or_e_out  out  1 = interrupt, 0 = exception (0 when take_out = 0)
//     cause_out   out  cause code (0 when take_out = 0)
// ---------------------------------------------------------------------------
module trap_priority_enc
   import trap_ctrl_unit_pkg::*;
(
   input  exc_flags_t  exc_in,
   input  logic        mie_in,
   input  irq_bits_t   irq_in,
   output logic        take_out,
   output logic        i_or_e_out,
   output logic [3:0]  cause_out
);

   logic mei_s;
   logic msi_s;
   logic mti_s;

   // Interrupt sources qualified by the global machine interrupt enable
   always_comb begin
      mei_s = mie_in & irq_in.meie & irq_in.meip;
      msi_s = mie_in & irq_in.msie & irq_in.msip;
      mti_s = mie_in & irq_in.mtie & irq_in.mtip;
   end

   // Fixed-priority selection of the winning trap source
   always_comb begin
      take_out   = 1'b1;
      i_or_e_out = 1'b0;
      cause_out  = 4'd0;
      if (mei_s) begin
         i_or_e_out = 1'b1;
         cause_out  = CAUSE_MEI;
      end else if (msi_s) begin
         i_or_e_out = 1'b1;
         cause_out  = CAUSE_MSI;
      end else if (mti_s) begin
         i_or_e_out = 1'b1;
         cause_out  = CAUSE_MTI;
      end else if (exc_in.misaligned_instr) begin
         cause_out  = CAUSE_MISALIGNED_INSTR;
      end else if (exc_in.illegal_instr) begin
         cause_out  = CAUSE_ILLEGAL_INSTR;
      end else if (exc_in.ebreak) begin
         cause_out  = CAUSE_BREAKPOINT;
      end else if (exc_in.misaligned_load) begin
         cause_out  = CAUSE_MISALIGNED_LOAD;
      end else if (exc_in.misaligned_store) begin
         cause_out  = CAUSE_MISALIGNED_STORE;
      end else if (exc_in.ecall) begin
         cause_out  = CAUSE_ECALL_M;
      end else begin
         take_out   = 1'b0;
      end
   end

endmodule

// File: rtl/trap_ctrl_unit.sv
// ---------------------------------------------------------------------------
// trap_ctrl_unit
//   Machine-mode trap controller driving the CSR file's trap interface.
//   Decides trap entry / MRET in the OPERATING state combinationally (Mealy),
//   then spends one cycle redirecting the PC (TRAP_TAKEN / TRAP_RETURN).
//   Optional feature macro: TRAP_CTRL_WFI_EN adds wfi_in and the WFI_WAIT
//   state; without it WFI behaves as a NOP.
//   Ports:
//     clk_in, rst_in             clock, synchronous active-high reset
//     stall_in                   hold FSM, suppress all strobes
//     illegal_instr_in, misaligned_instr_in, misaligned_load_in,
//     misaligned_store_in, ecall_in, ebreak_in, mret_in   decoder flags
//     mie_in                     mstatus.MIE
//     meie_in, mtie_in, msie_in  mie register bits
//     meip_in, mtip_in, msip_in  mip register bits
//     wfi_in                     (TRAP_CTRL_WFI_EN only) WFI decoded
//     i_or_e_out, cause_out      trap type/cause, valid with set_cause_out
//     set_cause_out, set_epc_out, mie_clear_out, mie_set_out,
//     instret_inc_out            CSR strobes
//     pc_src_out                 00 boot, 01 epc, 10 trap vector, 11 next PC
//     flush_out                  kill the instruction in flight
// ---------------------------------------------------------------------------
module trap_ctrl_unit
   import trap_ctrl_unit_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        stall_in,
   input  logic        illegal_instr_in,
   input  logic        misaligned_instr_in,
   input  logic        misaligned_load_in,
   input  logic        misaligned_store_in,
   input  logic        ecall_in,
   input  logic        ebreak_in,
   input  logic        mret_in,
`ifdef TRAP_CTRL_WFI_EN
   input  logic        wfi_in,
`endif
   input  logic        mie_in,
   input  logic        meie_in,
   input  logic        mtie_in,
   input  logic        msie_in,
   input  logic        meip_in,
   input  logic        mtip_in,
   input  logic        msip_in,
   output logic        i_or_e_out,
   output logic [3:0]  cause_out,
   output logic        set_cause_out,
   output logic        set_epc_out,
   output logic        mie_clear_out,
   output logic        mie_set_out,
   output logic        instret_inc_out,
   output logic [1:0]  pc_src_out,
   output logic        flush_out
);

   trap_state_e state_q;
   trap_state_e state_d;

   exc_flags_t  exc_s;
   irq_bits_t   irq_s;
   logic        take_s;
   logic        enc_i_or_e_s;
   logic [3:0]  enc_cause_s;
   // Strobes may only fire when the FSM is free to advance this cycle
   logic        advance_s;

   // Group the raw flag inputs for the arbiter
   always_comb begin
      exc_s.misaligned_instr = misaligned_instr_in;
      exc_s.illegal_instr    = illegal_instr_in;
      exc_s.ebreak           = ebreak_in;
      exc_s.misaligned_load  = misaligned_load_in;
      exc_s.misaligned_store = misaligned_store_in;
      exc_s.ecall            = ecall_in;
      irq_s.meie             = meie_in;
      irq_s.mtie             = mtie_in;
      irq_s.msie             = msie_in;
      irq_s.meip             = meip_in;
      irq_s.mtip             = mtip_in;
      irq_s.msip             = msip_in;
      advance_s              = ~rst_in & ~stall_in;
   end

   trap_priority_enc u_prio (
      .exc_in     (exc_s),
      .mie_in     (mie_in),
      .irq_in     (irq_s),
      .take_out   (take_s),
      .i_or_e_out (enc_i_or_e_s),
      .cause_out  (enc_cause_s)
   );

   // Next-state and output decode
   always_comb begin
      state_d         = state_q;
      pc_src_out      = PC_SRC_NEXT;
      flush_out       = 1'b0;
      set_epc_out     = 1'b0;
      set_cause_out   = 1'b0;
      mie_clear_out   = 1'b0;
      mie_set_out     = 1'b0;
      instret_inc_out = 1'b0;
      i_or_e_out      = 1'b0;
      cause_out       = 4'd0;
      case (state_q)
         ST_RESET: begin
            // Stall does not hold RESET
            pc_src_out = PC_SRC_BOOT;
            flush_out  = 1'b1;
            state_d    = ST_OPERATING;
         end
         ST_OPERATING: begin
            pc_src_out = PC_SRC_NEXT;
            if (!advance_s) begin
               state_d = ST_OPERATING;
            end else if (take_s) begin
               set_epc_out   = 1'b1;
               set_cause_out = 1'b1;
               mie_clear_out = 1'b1;
               i_or_e_out    = enc_i_or_e_s;
               cause_out     = enc_cause_s;
               flush_out     = 1'b1;
               state_d       = ST_TRAP_TAKEN;
            end else if (mret_in) begin
               mie_set_out     = 1'b1;
               instret_inc_out = 1'b1;
               flush_out       = 1'b1;
               state_d         = ST_TRAP_RETURN;
`ifdef TRAP_CTRL_WFI_EN
            end else if (wfi_in) begin
               instret_inc_out = 1'b1;
               state_d         = ST_WFI_WAIT;
`endif
            end else begin
               instret_inc_out = 1'b1;
               state_d         = ST_OPERATING;
            end
         end
         ST_TRAP_TAKEN: begin
            pc_src_out = PC_SRC_TRAP;
            flush_out  = 1'b1;
            if (stall_in) begin
               state_d = ST_TRAP_TAKEN;
            end else begin
               state_d = ST_OPERATING;
            end
         end
         ST_TRAP_RETURN: begin
            pc_src_out = PC_SRC_EPC;
            flush_out  = 1'b1;
            if (stall_in) begin
               state_d = ST_TRAP_RETURN;
            end else begin
               state_d = ST_OPERATING;
            end
         end
`ifdef TRAP_CTRL_WFI_EN
         ST_WFI_WAIT: begin
            // Wake on any enabled+pending source even with MIE clear
            pc_src_out = PC_SRC_NEXT;
            flush_out  = 1'b1;
            if (!stall_in && irq_pending(irq_s)) begin
               state_d = ST_OPERATING;
            end else begin
               state_d = ST_WFI_WAIT;
            end
         end
`endif
         default: begin
            pc_src_out = PC_SRC_BOOT;
            flush_out  = 1'b1;
            state_d    = ST_RESET;
         end
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: tb/tb_trap_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl_unit
//   Self-checking bench for trap_ctrl_unit. A behavioural model tracks the
//   controller phase as a plain integer and derives expected outputs from
//   priority tables; directed scenarios are followed by random stimulus.
//   Build with TRAP_CTRL_WFI_EN defined to also cover the WFI path.
// ---------------------------------------------------------------------------
module tb_trap_ctrl_unit;

`ifdef TRAP_CTRL_WFI_EN
   localparam bit WFI_EN = 1'b1;
`else
   localparam bit WFI_EN = 1'b0;
`endif

   typedef struct packed {
      logic rst;
      logic stall;
      logic mis_i;
      logic ill;
      logic ebreak;
      logic mis_l;
      logic mis_s;
      logic ecall;
      logic mret;
      logic wfi;
      logic mie;
      logic meie;
      logic mtie;
      logic msie;
      logic meip;
      logic mtip;
      logic msip;
   } in_t;

   // Model phases
   localparam int P_RESET = 0;
   localparam int P_OP    = 1;
   localparam int P_TAKEN = 2;
   localparam int P_RET   = 3;
   localparam int P_WFI   = 4;

   logic        clk = 1'b0;
   in_t         in_s;
   logic        i_or_e_out, set_cause_out, set_epc_out, mie_clear_out;
   logic        mie_set_out, instret_inc_out, flush_out;
   logic [3:0]  cause_out;
   logic [1:0]  pc_src_out;

   int          m_state;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [12:0] obs, exp;

   always #5 clk = ~clk;

   trap_ctrl_unit dut (
      .clk_in              (clk),
      .rst_in              (in_s.rst),
      .stall_in            (in_s.stall),
      .illegal_instr_in    (in_s.ill),
      .misaligned_instr_in (in_s.mis_i),
      .misaligned_load_in  (in_s.mis_l),
      .misaligned_store_in (in_s.mis_s),
      .ecall_in            (in_s.ecall),
      .ebreak_in           (in_s.ebreak),
      .mret_in             (in_s.mret),
`ifdef TRAP_CTRL_WFI_EN
      .wfi_in              (in_s.wfi),
`endif
      .mie_in              (in_s.mie),
      .meie_in             (in_s.meie),
      .mtie_in             (in_s.mtie),
      .msie_in             (in_s.msie),
      .meip_in             (in_s.meip),
      .mtip_in             (in_s.mtip),
      .msip_in             (in_s.msip),
      .i_or_e_out          (i_or_e_out),
      .cause_out           (cause_out),
      .set_cause_out       (set_cause_out),
      .set_epc_out         (set_epc_out),
      .mie_clear_out       (mie_clear_out),
      .mie_set_out         (mie_set_out),
      .instret_inc_out     (instret_inc_out),
      .pc_src_out          (pc_src_out),
      .flush_out           (flush_out)
   );

   // {take, i_or_e, cause} from the priority tables
   function automatic logic [5:0] find_trap(input in_t x);
      bit irq_act[3];
      int irq_code[3];
      bit exc_act[6];
      int exc_code[6];
      irq_act  = '{x.mie & x.meie & x.meip, x.mie & x.msie & x.msip, x.mie & x.mtie & x.mtip};
      irq_code = '{11, 3, 7};
      exc_act  = '{x.mis_i, x.ill, x.ebreak, x.mis_l, x.mis_s, x.ecall};
      exc_code = '{0, 2, 3, 4, 6, 11};
      for (int i = 0; i < 3; i++) begin
         if (irq_act[i]) return {1'b1, 1'b1, 4'(irq_code[i])};
      end
      for (int i = 0; i < 6; i++) begin
         if (exc_act[i]) return {1'b1, 1'b0, 4'(exc_code[i])};
      end
      return 6'd0;
   endfunction

   // Expected {i_or_e, cause, set_cause, set_epc, mie_clear, mie_set, instret_inc, pc_src, flush}
   function automatic logic [12:0] exp_out(input int st, input in_t x);
      logic [1:0] pc;
      logic       fl, tk, ie, ms, inst;
      logic [3:0] c;
      logic [5:0] t;
      pc = 2'b00; fl = 1'b1; tk = 1'b0; ie = 1'b0; ms = 1'b0; inst = 1'b0; c = 4'd0;
      case (st)
         P_RESET: begin pc = 2'b00; fl = 1'b1; end
         P_OP: begin
            pc = 2'b11; fl = 1'b0;
            if (!x.rst && !x.stall) begin
               t = find_trap(x);
               if (t[5]) begin
                  tk = 1'b1; ie = t[4]; c = t[3:0]; fl = 1'b1;
               end else if (x.mret) begin
                  ms = 1'b1; inst = 1'b1; fl = 1'b1;
               end else begin
                  inst = 1'b1;
               end
            end
         end
         P_TAKEN: begin pc = 2'b10; fl = 1'b1; end
         P_RET:   begin pc = 2'b01; fl = 1'b1; end
         default: begin pc = 2'b11; fl = 1'b1; end
      endcase
      return {ie, c, tk, tk, tk, ms, inst, pc, fl};
   endfunction

   function automatic int model_next(input int st, input in_t x);
      logic wake;
      wake = (x.meie & x.meip) | (x.msie & x.msip) | (x.mtie & x.mtip);
      if (x.rst) return P_RESET;
      case (st)
         P_RESET: return P_OP;
         P_OP: begin
            if (x.stall) return P_OP;
            if (find_trap(x) >= 6'd32) return P_TAKEN;
            if (x.mret) return P_RET;
            if (WFI_EN && x.wfi) return P_WFI;
            return P_OP;
         end
         P_TAKEN, P_RET: return x.stall ? st : P_OP;
         P_WFI: return (!x.stall && wake) ? P_OP : P_WFI;
         default: return P_RESET;
      endcase
   endfunction

   // Apply one cycle of stimulus, capture outputs mid-cycle, advance the model
   task automatic run_cycle(input in_t x, output logic [12:0] o, output logic [12:0] e);
      in_s = x;
      @(negedge clk);
      o = {i_or_e_out, cause_out, set_cause_out, set_epc_out, mie_clear_out,
           mie_set_out, instret_inc_out, pc_src_out, flush_out};
      e = exp_out(m_state, x);
      @(posedge clk);
      m_state = model_next(m_state, x);
      #1;
   endtask

   task automatic test_reset();
      in_t x;
      for (int i = 0; i < 5; i++) begin
         x = '0;
         x.rst = (i < 3);
         x.stall = (i == 3);   // stall must not hold RESET
         run_cycle(x, obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset cyc%0d got=%b exp=%b", i, obs, exp);
         end
      end
      // After one released RESET cycle the PC mux must select next PC
      n_tests++;
      if (obs[2:1] !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_pc_next got=%b exp=11", obs[2:1]);
      end
   endtask

   task automatic test_ecall();
      in_t q[$];
      in_t x;
      x = '0; x.ecall = 1'b1; q.push_back(x);
      x = '0; q.push_back(x); q.push_back(x);
      foreach (q[i]) begin
         run_cycle(q[i], obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL ecall cyc%0d got=%b exp=%b", i, obs, exp);
         end
         if (i == 0) begin
            n_tests++;
            if (obs !== 13'b0_1011_1110_0111) begin
               n_fail++;
               $display("FAIL ecall_entry got=%b exp=%b", obs, 13'b0_1011_1110_0111);
            end
         end
      end
   endtask

   task automatic test_irq_priority();
      in_t q[$];
      in_t x;
      in_t idle;
      idle = '0;
      x = '0; x.mie = 1'b1; x.mtie = 1'b1; x.mtip = 1'b1; x.meie = 1'b1; x.meip = 1'b1; x.ill = 1'b1;
      q.push_back(x); q.push_back(idle);
      x.meip = 1'b0; q.push_back(x); q.push_back(idle);
      x.mie = 1'b0;  q.push_back(x); q.push_back(idle);
      x = '0; x.msie = 1'b1; x.msip = 1'b1; x.mtie = 1'b1; x.mtip = 1'b1; x.mie = 1'b1;
      q.push_back(x); q.push_back(idle);
      x = '0; x.mis_l = 1'b1; x.mis_s = 1'b1; x.ecall = 1'b1; q.push_back(x); q.push_back(idle);
      x = '0; x.mis_s = 1'b1; x.mret = 1'b1; q.push_back(x); q.push_back(idle);
      foreach (q[i]) begin
         run_cycle(q[i], obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL irq_prio cyc%0d got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_mret();
      in_t q[$];
      in_t x;
      x = '0; x.mret = 1'b1; q.push_back(x);
      x = '0; q.push_back(x); q.push_back(x);
      x = '0; x.mret = 1'b1; q.push_back(x);
      x = '0; x.stall = 1'b1; q.push_back(x);   // TRAP_RETURN held by stall
      x = '0; q.push_back(x); q.push_back(x);
      foreach (q[i]) begin
         run_cycle(q[i], obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL mret cyc%0d got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_stall();
      in_t x;
      for (int i = 0; i < 7; i++) begin
         x = '0;
         x.ebreak = (i < 5);
         x.stall  = (i < 4);
         run_cycle(x, obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL stall cyc%0d got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      in_t q[$];
      in_t x;
      x = '0; x.ecall = 1'b1; q.push_back(x);
      x = '0; x.rst = 1'b1; q.push_back(x);           // reset while TRAP_TAKEN
      x = '0; q.push_back(x); q.push_back(x);
      x = '0; x.rst = 1'b1; x.ecall = 1'b1; q.push_back(x);  // no strobe under reset
      x = '0; q.push_back(x); q.push_back(x);
      foreach (q[i]) begin
         run_cycle(q[i], obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_mid cyc%0d got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_wfi();
      in_t q[$];
      in_t x;
      x = '0; x.rst = 1'b1; q.push_back(x);
      x = '0; q.push_back(x);
      x = '0; x.wfi = 1'b1; q.push_back(x);
      x = '0; q.push_back(x); q.push_back(x);
      x = '0; x.msie = 1'b1; x.msip = 1'b1; x.mie = 1'b1; q.push_back(x); q.push_back(x);
      x = '0; q.push_back(x); q.push_back(x);
      foreach (q[i]) begin
         run_cycle(q[i], obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL wfi cyc%0d got=%b exp=%b", i, obs, exp);
         end
      end
   endtask

   task automatic test_random();
      in_t x;
      for (int i = 0; i < 500; i++) begin
         x = '0;
         x.rst    = ($urandom_range(0, 31) == 0);
         x.stall  = ($urandom_range(0, 3) == 0);
         x.mis_i  = ($urandom_range(0, 11) == 0);
         x.ill    = ($urandom_range(0, 9) == 0);
         x.ebreak = ($urandom_range(0, 9) == 0);
         x.mis_l  = ($urandom_range(0, 9) == 0);
         x.mis_s  = ($urandom_range(0, 9) == 0);
         x.ecall  = ($urandom_range(0, 9) == 0);
         x.mret   = ($urandom_range(0, 5) == 0);
         x.wfi    = WFI_EN && ($urandom_range(0, 7) == 0);
         x.mie    = $urandom_range(0, 1) == 1;
         x.meie   = $urandom_range(0, 1) == 1;
         x.mtie   = $urandom_range(0, 1) == 1;
         x.msie   = $urandom_range(0, 1) == 1;
         x.meip   = ($urandom_range(0, 3) == 0);
         x.mtip   = ($urandom_range(0, 3) == 0);
         x.msip   = ($urandom_range(0, 3) == 0);
         run_cycle(x, obs, exp);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL random cyc%0d in=%b got=%b exp=%b", i, x, obs, exp);
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_s = '0;
      in_s.rst = 1'b1;
      m_state = P_RESET;
      @(posedge clk);
      #1;
      test_reset();
      test_ecall();
      test_irq_priority();
      test_mret();
      test_stall();
      test_reset_mid();
      if (WFI_EN) test_wfi();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
